key_schedule_seq: RTL and testbench



---
 rtl/key_schedule_seq.sv | 205 ++++++++++++++++++++
 tb/tb_key_schedule_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: iterative PRESENT-style round-key generator.
// Loads a master key and emits one round key per rk_valid/rk_ready handshake.
// Working key i+1 = rotl(K_i, ROT), top nibble through S-box, round index XORed
// into the low CNT_W bits; round key i = top RK_W bits of working key i.
// Optional feature macro: KEY_SCHED_REVERSE_EN adds the reverse port, a
// ROUNDS x RK_W key buffer, and FILL/RPLY states that replay the keys
// last-to-first for decryption. With the macro undefined only forward order exists.
module key_schedule_seq #(
    parameter int KEY_W  = 20,
    parameter int RK_W   = 16,
    parameter int ROUNDS = 8,
    parameter int ROT    = 13,
    localparam int CNT_W = ($clog2(ROUNDS) > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
`ifdef KEY_SCHED_REVERSE_EN
    input  logic              reverse,
`endif
    output logic              load_ready,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [RK_W-1:0]   rk_out,
    output logic [CNT_W-1:0]  rk_idx,
    output logic              done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FILL = 2'd2,
        S_RPLY = 2'd3
    } state_t;

    state_t            state_reg;
    logic [KEY_W-1:0]  work_key_reg;
    logic [KEY_W-1:0]  rot_key;
    logic [KEY_W-1:0]  work_key_next;
    logic [CNT_W-1:0]  idx_next;
    logic [RK_W-1:0]   rk_cur;
    logic              load_ready_reg;
    logic              rk_valid_reg;
    logic [RK_W-1:0]   rk_out_reg;
    logic [CNT_W-1:0]  rk_idx_reg;
    logic              done_reg;
    logic              handshake;

    // 4-bit substitution box applied to the top nibble of the rotated key
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // Substitution then round-constant injection on an already rotated key.
    // The XOR happens after the S-box so that narrow keys where the two
    // fields overlap still follow the defined order.
    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] rotated,
                                                    input logic [CNT_W-1:0] rnd);
        logic [KEY_W-1:0] k;
        k = rotated;
        k[KEY_W-1 -: 4] = sbox4(rotated[KEY_W-1 -: 4]);
        k = k ^ KEY_W'(rnd);
        return k;
    endfunction

    // Left rotation by ROT is pure wiring: bit gi takes bit gi-ROT (mod KEY_W)
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_rot
        assign rot_key[gi] = work_key_reg[(gi + KEY_W - ROT) % KEY_W];
    end

    // The update index is the index of the key being produced, i.e. current idx + 1
    assign idx_next      = rk_idx_reg + ONE_IDX;
    assign work_key_next = key_update(rot_key, idx_next);
    assign rk_cur        = work_key_reg[KEY_W-1 -: RK_W];
    assign handshake     = rk_valid_reg & rk_ready;

`ifdef KEY_SCHED_REVERSE_EN
    logic [RK_W-1:0] key_buf [ROUNDS];

    // Store one round key per FILL cycle at the current round index
    always_ff @(posedge clk) begin
        if (state_reg == S_FILL) begin
            key_buf[rk_idx_reg] <= rk_cur;
        end
    end
`endif

    // Control FSM with registered outputs; rk_out only changes on a handshake
    // or a load, so it never depends combinationally on rk_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            work_key_reg   <= '0;
            load_ready_reg <= 1'b1;
            rk_valid_reg   <= 1'b0;
            rk_out_reg     <= '0;
            rk_idx_reg     <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        work_key_reg   <= key_in;
                        rk_idx_reg     <= '0;
                        load_ready_reg <= 1'b0;
`ifdef KEY_SCHED_REVERSE_EN
                        if (reverse) begin
                            state_reg <= S_FILL;
                        end else begin
                            state_reg    <= S_EMIT;
                            rk_valid_reg <= 1'b1;
                            rk_out_reg   <= key_in[KEY_W-1 -: RK_W];
                        end
`else
                        state_reg    <= S_EMIT;
                        rk_valid_reg <= 1'b1;
                        rk_out_reg   <= key_in[KEY_W-1 -: RK_W];
`endif
                    end
                end

                S_EMIT: begin
                    if (handshake) begin
                        if (rk_idx_reg == LAST_IDX) begin
                            state_reg      <= S_IDLE;
                            rk_valid_reg   <= 1'b0;
                            load_ready_reg <= 1'b1;
                            done_reg       <= 1'b1;
                        end else begin
                            work_key_reg <= work_key_next;
                            rk_out_reg   <= work_key_next[KEY_W-1 -: RK_W];
                            rk_idx_reg   <= idx_next;
                        end
                    end
                end

`ifdef KEY_SCHED_REVERSE_EN
                S_FILL: begin
                    if (rk_idx_reg == LAST_IDX) begin
                        // The last entry is being written this cycle, so the
                        // first replayed key is forwarded from the working key.
                        state_reg    <= S_RPLY;
                        rk_valid_reg <= 1'b1;
                        rk_out_reg   <= rk_cur;
                    end else begin
                        work_key_reg <= work_key_next;
                        rk_idx_reg   <= idx_next;
                    end
                end

                S_RPLY: begin
                    if (handshake) begin
                        if (rk_idx_reg == '0) begin
                            state_reg      <= S_IDLE;
                            rk_valid_reg   <= 1'b0;
                            load_ready_reg <= 1'b1;
                            done_reg       <= 1'b1;
                        end else begin
                            rk_out_reg <= key_buf[rk_idx_reg - ONE_IDX];
                            rk_idx_reg <= rk_idx_reg - ONE_IDX;
                        end
                    end
                end
`endif

                default: begin
                    state_reg      <= S_IDLE;
                    rk_valid_reg   <= 1'b0;
                    load_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = load_ready_reg;
    assign rk_valid   = rk_valid_reg;
    assign rk_out     = rk_out_reg;
    assign rk_idx     = rk_idx_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: randomized jobs, expected keys
// pushed into per-instance queues from a plain-arithmetic reference model,
// and independent monitors that compare every valid cycle and pop on handshake.
module tb_key_schedule_seq;

    localparam int KW  = 20, RW  = 16, NR  = 8,  RT  = 13, CW  = 3;
    localparam int KW2 = 80, RW2 = 64, NR2 = 32, RT2 = 61, CW2 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           start, rk_ready, load_ready, rk_valid, done;
    logic [KW-1:0]  key_in;
    logic [RW-1:0]  rk_out;
    logic [CW-1:0]  rk_idx;

    logic           start2, rk_ready2, load_ready2, rk_valid2, done2;
    logic [KW2-1:0] key_in2;
    logic [RW2-1:0] rk_out2;
    logic [CW2-1:0] rk_idx2;
`ifdef KEY_SCHED_REVERSE_EN
    logic           reverse, reverse2;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           idx;
        logic [127:0] rk;
        bit           last;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    bit   done_exp1 = 1'b0;
    bit   done_exp2 = 1'b0;

    key_schedule_seq #(.KEY_W(KW), .RK_W(RW), .ROUNDS(NR), .ROT(RT)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
`ifdef KEY_SCHED_REVERSE_EN
        .reverse(reverse),
`endif
        .load_ready(load_ready), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_out(rk_out), .rk_idx(rk_idx), .done(done)
    );

    key_schedule_seq #(.KEY_W(KW2), .RK_W(RW2), .ROUNDS(NR2), .ROT(RT2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .key_in(key_in2),
`ifdef KEY_SCHED_REVERSE_EN
        .reverse(reverse2),
`endif
        .load_ready(load_ready2), .rk_valid(rk_valid2), .rk_ready(rk_ready2),
        .rk_out(rk_out2), .rk_idx(rk_idx2), .done(done2)
    );

    // Reference: round key i computed from scratch with shifts and masks
    function automatic logic [127:0] model_rk(input logic [127:0] key, input int i,
                                              input int kw, input int rw, input int rot);
        logic [127:0] mask, k;
        int nib;
        int sbox [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
        mask = (128'd1 << kw) - 128'd1;
        k = key & mask;
        for (int r = 1; r <= i; r++) begin
            k = ((k << rot) | (k >> (kw - rot))) & mask;
            nib = int'((k >> (kw - 4)) & 128'hF);
            k = (k & ~(128'hF << (kw - 4))) | (128'(sbox[nib]) << (kw - 4));
            k = k ^ 128'(r);
        end
        return k >> (kw - rw);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [KW-1:0] rand_key1();
        logic [31:0] r;
        r = $urandom;
        return r[KW-1:0];
    endfunction

    function automatic logic [KW2-1:0] rand_key2();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[KW2-1:0];
    endfunction

    // Monitor for the default-parameter instance
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("done1", done, done_exp1);
                done_exp1 = 1'b0;
                if (rk_valid) begin
                    if (q1.size() == 0) begin
                        chk("unexpected_key1", 1'b1, 1'b0);
                    end else begin
                        chk("rk_out1", rk_out, q1[0].rk);
                        chk("rk_idx1", rk_idx, q1[0].idx);
                        if (rk_ready) begin
                            done_exp1 = q1[0].last;
                            void'(q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    // Monitor for the wide instance
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("done2", done2, done_exp2);
                done_exp2 = 1'b0;
                if (rk_valid2) begin
                    if (q2.size() == 0) begin
                        chk("unexpected_key2", 1'b1, 1'b0);
                    end else begin
                        chk("rk_out2", rk_out2, q2[0].rk);
                        chk("rk_idx2", rk_idx2, q2[0].idx);
                        if (rk_ready2) begin
                            done_exp2 = q2[0].last;
                            void'(q2.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic run1(input logic [KW-1:0] key, input bit rev, input bit rnd_ready,
                        input bit inject, input bit abort);
        exp_t e;
        int n;
        bit seen, inj, aborted;
        logic [15:0] tbl [3] = '{16'h0000, 16'hC000, 16'hC380};
        for (int j = 0; j < NR; j++) begin
            e.idx  = rev ? (NR - 1 - j) : j;
            e.rk   = model_rk(128'(key), e.idx, KW, RW, RT);
            e.last = rev ? (e.idx == 0) : (e.idx == NR - 1);
            q1.push_back(e);
        end
        $display("job1 key=%05h rev=%0d rnd_ready=%0d inject=%0d abort=%0d", key, rev, rnd_ready, inject, abort);
        chk("load_ready_idle", load_ready, 1'b1);
        start  = 1'b1;
        key_in = key;
`ifdef KEY_SCHED_REVERSE_EN
        reverse = rev;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; seen = 1'b0; inj = 1'b0; aborted = 1'b0;
        chk("load_ready_busy", load_ready, 1'b0);
        while (!seen && n < 20 * NR) begin
            if (!rnd_ready && !rev && n == 1) begin
                chk("first_valid_fwd", rk_valid, 1'b1);
                chk("first_idx_fwd", rk_idx, 0);
            end
            if (!rnd_ready && rev && n == NR) chk("fill_no_valid", rk_valid, 1'b0);
            if (!rnd_ready && rev && n == NR + 1) begin
                chk("first_valid_rev", rk_valid, 1'b1);
                chk("first_idx_rev", rk_idx, NR - 1);
            end
            if (key == '0 && !rnd_ready && !rev && n <= 3) chk("vec_fwd", rk_out, tbl[n-1]);
            if (key == '0 && !rnd_ready && rev && n >= 2*NR-2 && n <= 2*NR) chk("vec_rev", rk_out, tbl[2*NR-n]);
            if (abort && rk_valid && rk_idx == 3'd4) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                q1.delete();
                done_exp1 = 1'b0;
                aborted = 1'b1;
                chk("abort_reached", aborted, 1'b1);
                chk("abort_valid", rk_valid, 1'b0);
                chk("abort_load_ready", load_ready, 1'b1);
                chk("abort_done", done, 1'b0);
                return;
            end
            rk_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (inject && !inj && rk_valid && rk_idx == 3'd3) begin
                start  = 1'b1;
                key_in = rand_key1();
                inj    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (abort) chk("abort_reached", aborted, 1'b1);
        if (inject) chk("inject_issued", inj, 1'b1);
        chk("done1_seen", seen, 1'b1);
        if (!rnd_ready) chk("done1_cycle", n, rev ? 2*NR+1 : NR+1);
        chk("load_ready_at_done", load_ready, 1'b1);
        chk("queue1_empty", q1.size(), 0);
    endtask

    task automatic run2(input logic [KW2-1:0] key, input bit rev, input bit rnd_ready);
        exp_t e;
        int n;
        bit seen;
        for (int j = 0; j < NR2; j++) begin
            e.idx  = rev ? (NR2 - 1 - j) : j;
            e.rk   = model_rk(128'(key), e.idx, KW2, RW2, RT2);
            e.last = rev ? (e.idx == 0) : (e.idx == NR2 - 1);
            q2.push_back(e);
        end
        $display("job2 key=%020h rev=%0d rnd_ready=%0d", key, rev, rnd_ready);
        chk("load_ready2_idle", load_ready2, 1'b1);
        start2  = 1'b1;
        key_in2 = key;
`ifdef KEY_SCHED_REVERSE_EN
        reverse2 = rev;
`endif
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 1; seen = 1'b0;
        while (!seen && n < 20 * NR2) begin
            rk_ready2 = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(posedge clk); #1;
            n++;
            if (done2) seen = 1'b1;
        end
        chk("done2_seen", seen, 1'b1);
        if (!rnd_ready) chk("done2_cycle", n, rev ? 2*NR2+1 : NR2+1);
        chk("queue2_empty", q2.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; rk_ready = 1'b0; key_in = '0;
        start2 = 1'b0; rk_ready2 = 1'b0; key_in2 = '0;
`ifdef KEY_SCHED_REVERSE_EN
        reverse = 1'b0; reverse2 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_rk_out", rk_out, 0);
        chk("rst_rk_idx", rk_idx, 0);
        chk("rst_done", done, 1'b0);
        chk("rst_load_ready2", load_ready2, 1'b1);
        chk("rst_rk_valid2", rk_valid2, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        run1('0, 1'b0, 1'b0, 1'b0, 1'b0);
        run1('0, 1'b0, 1'b1, 1'b0, 1'b0);
        run1(rand_key1(), 1'b0, 1'b1, 1'b1, 1'b0);
        run1(rand_key1(), 1'b0, 1'b0, 1'b0, 1'b1);
        run1('0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            run1(rand_key1(), 1'b0, j[0], 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
`ifdef KEY_SCHED_REVERSE_EN
        run1('0, 1'b1, 1'b0, 1'b0, 1'b0);
        run1(rand_key1(), 1'b1, 1'b1, 1'b0, 1'b0);
        run1(rand_key1(), 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        run2(rand_key2(), 1'b0, 1'b0);
        run2(rand_key2(), 1'b0, 1'b1);
`ifdef KEY_SCHED_REVERSE_EN
        run2(rand_key2(), 1'b1, 1'b1);
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
